// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port data memory.
// Stores queue in a circular FIFO and drain when no load owns the port;
// loads forward the newest matching queued store. A full buffer starved
// by loads for STALL_LIMIT cycles forces one drain by stalling the load.
module store_buffer #(
    parameter int DEPTH       = 4,
    parameter int AW          = 10,
    parameter int DW          = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_adr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_adr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          empty,
    output logic [AW-1:0] MemAdr,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [7:0]    LIMIT = 8'(STALL_LIMIT);

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    stall_q, stall_d;

    logic   full, force_drain, drain, push, svc_ld, fwd_hit;
    logic [DW-1:0] fwd_data;
    entry_t head_e;

    assign full        = (cnt_q == FULL);
    assign force_drain = full && (stall_q == LIMIT);
    assign st_ready    = !full;
    assign empty       = (cnt_q == '0);
    assign ld_stall    = ld_req && force_drain;
    assign svc_ld      = ld_req && !force_drain;
    assign drain       = !empty && (!ld_req || force_drain);
    assign push        = st_valid && st_ready;
    assign head_e      = fifo_q[head_q];

    // Memory port: a serviced load owns the port, otherwise the head entry drains
    assign MemRead  = svc_ld;
    assign MemWrite = !svc_ld && drain;
    assign MemAdr   = svc_ld ? ld_adr : head_e.adr;
    assign MemWData = head_e.data;
    assign ld_data  = fwd_hit ? fwd_data : MemData;

    // Forwarding: scan oldest to newest so the newest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q && fifo_q[head_q + PW'(i)].adr == ld_adr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_q[head_q + PW'(i)].data;
            end
        end
    end

    // Next-state for pointers, occupancy and the starvation counter
    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push  ? tail_q + PW'(1) : tail_q;
        cnt_d   = cnt_q + CW'(push) - CW'(drain);
        stall_d = stall_q;
        if (drain || !full)
            stall_d = '0;
        else if (ld_req && !force_drain)
            stall_d = stall_q + 8'd1;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Entry storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[tail_q] <= '{adr: st_adr, data: st_data};
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a cycle table with hand-derived
// expectations, then a random phase checked against a store scoreboard
// and a behavioural memory.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst, st_valid, st_ready, ld_req, ld_stall, empty;
    logic [9:0]  st_adr, ld_adr, MemAdr;
    logic [15:0] st_data, ld_data, MemWData, MemData;
    logic        MemRead, MemWrite;

    store_buffer #(.DEPTH(4), .AW(10), .DW(16), .STALL_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_adr(st_adr),
        .st_data(st_data), .st_ready(st_ready), .ld_req(ld_req),
        .ld_adr(ld_adr), .ld_data(ld_data), .ld_stall(ld_stall),
        .empty(empty), .MemAdr(MemAdr), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemWData(MemWData), .MemData(MemData)
    );

    always #5 clk = ~clk;

    // Data memory model: preset pattern 0x8000|adr, written on MemWrite
    logic [15:0] mem [1024];
    logic        tb_init;
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h8000 | 16'(i);
        end else if (MemWrite) begin
            mem[MemAdr] <= MemWData;
        end
    end
    assign MemData = mem[MemAdr];

    typedef struct {
        logic rst, stv; logic [9:0] sadr; logic [15:0] sdat;
        logic ldr; logic [9:0] ladr;
        logic rdy, emp, stl, rd, wr; logic [9:0] madr; logic [15:0] ldat;
    } vec_t;

    typedef struct { logic [9:0] adr; logic [15:0] data; } st_t;

    vec_t tv[$];
    st_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic sv, input logic [9:0] sa, input logic [15:0] sd,
                       input logic lr, input logic [9:0] la, input logic rdy, input logic emp,
                       input logic stl, input logic rd, input logic wr, input logic [9:0] ma,
                       input logic [15:0] ld);
        vec_t v;
        v.rst = r; v.stv = sv; v.sadr = sa; v.sdat = sd; v.ldr = lr; v.ladr = la;
        v.rdy = rdy; v.emp = emp; v.stl = stl; v.rd = rd; v.wr = wr; v.madr = ma; v.ldat = ld;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare a drain against the oldest outstanding store, then track acceptances
    task automatic sb_step(input string tag);
        st_t e;
        if (MemWrite) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected write"}, 32'(MemAdr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk({tag, " drain adr"}, 32'(MemAdr), 32'(e.adr));
                chk({tag, " drain data"}, 32'(MemWData), 32'(e.data));
            end
        end
        if (rst) sb.delete();
        else if (st_valid && st_ready) sb.push_back('{adr: st_adr, data: st_data});
    endtask

    function automatic logic [15:0] model_load(input logic [9:0] a);
        logic [15:0] r;
        r = mem[a];
        foreach (sb[i]) if (sb[i].adr == a) r = sb[i].data;
        return r;
    endfunction

    initial begin
        rst = 1'b1; tb_init = 1'b1; st_valid = 1'b0; st_adr = '0; st_data = '0;
        ld_req = 1'b0; ld_adr = '0;

        // reset, basic drain, forward newest, full, starvation, push+pop, mid-op reset
        add(1,0,10'h000,16'h0000,0,10'h000, 1,1,0,0,0,10'h000,16'h0000);
        add(0,1,10'h005,16'h1234,0,10'h000, 1,1,0,0,0,10'h000,16'h0000);
        add(0,0,10'h000,16'h0000,0,10'h000, 1,0,0,0,1,10'h005,16'h0000);
        add(0,0,10'h000,16'h0000,1,10'h005, 1,1,0,1,0,10'h005,16'h1234);
        add(0,1,10'h00A,16'h1111,1,10'h00A, 1,1,0,1,0,10'h00A,16'h800A);
        add(0,1,10'h00A,16'h2222,1,10'h00A, 1,0,0,1,0,10'h00A,16'h1111);
        add(0,1,10'h010,16'h3333,1,10'h00A, 1,0,0,1,0,10'h00A,16'h2222);
        add(0,1,10'h011,16'h4444,1,10'h00B, 1,0,0,1,0,10'h00B,16'h800B);
        add(0,1,10'h012,16'h5555,1,10'h011, 0,0,0,1,0,10'h011,16'h4444);
        for (int k = 0; k < 7; k++)
            add(0,0,10'h000,16'h0000,1,10'h010, 0,0,0,1,0,10'h010,16'h3333);
        add(0,0,10'h000,16'h0000,1,10'h010, 0,0,1,0,1,10'h00A,16'h0000);
        add(0,0,10'h000,16'h0000,1,10'h00A, 1,0,0,1,0,10'h00A,16'h2222);
        add(0,0,10'h000,16'h0000,0,10'h000, 1,0,0,0,1,10'h00A,16'h0000);
        add(0,1,10'h020,16'h6666,0,10'h000, 1,0,0,0,1,10'h010,16'h0000);
        add(0,0,10'h000,16'h0000,0,10'h000, 1,0,0,0,1,10'h011,16'h0000);
        add(0,0,10'h000,16'h0000,0,10'h000, 1,0,0,0,1,10'h020,16'h0000);
        add(0,0,10'h000,16'h0000,1,10'h020, 1,1,0,1,0,10'h020,16'h6666);
        add(0,0,10'h000,16'h0000,1,10'h00A, 1,1,0,1,0,10'h00A,16'h2222);
        add(0,1,10'h030,16'h7777,1,10'h031, 1,1,0,1,0,10'h031,16'h8031);
        add(1,1,10'h031,16'h8888,1,10'h030, 1,0,0,1,0,10'h030,16'h7777);
        add(0,0,10'h000,16'h0000,0,10'h000, 1,1,0,0,0,10'h000,16'h0000);
        add(0,0,10'h000,16'h0000,1,10'h030, 1,1,0,1,0,10'h030,16'h8030);

        repeat (2) @(negedge clk);
        tb_init = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; st_valid = tv[i].stv; st_adr = tv[i].sadr; st_data = tv[i].sdat;
            ld_req = tv[i].ldr; ld_adr = tv[i].ladr;
            #2;
            chk($sformatf("r%0d st_ready", i), 32'(st_ready), 32'(tv[i].rdy));
            chk($sformatf("r%0d empty", i),    32'(empty),    32'(tv[i].emp));
            chk($sformatf("r%0d ld_stall", i), 32'(ld_stall), 32'(tv[i].stl));
            chk($sformatf("r%0d MemRead", i),  32'(MemRead),  32'(tv[i].rd));
            chk($sformatf("r%0d MemWrite", i), 32'(MemWrite), 32'(tv[i].wr));
            if (tv[i].rd || tv[i].wr)
                chk($sformatf("r%0d MemAdr", i), 32'(MemAdr), 32'(tv[i].madr));
            if (tv[i].ldr && !tv[i].stl)
                chk($sformatf("r%0d ld_data", i), 32'(ld_data), 32'(tv[i].ldat));
            sb_step($sformatf("r%0d", i));
        end

        // Starvation from a fresh fill: stall must appear exactly after 8 full+blocked cycles
        begin
            int full_cyc = 0;
            bit seen = 0;
            for (int c = 0; c < 30 && !seen; c++) begin
                @(negedge clk);
                rst = 1'b0; ld_req = 1'b1; ld_adr = 10'h3FF;
                st_valid = 1'b1; st_adr = 10'h100 + 10'(c); st_data = 16'hC000 + 16'(c);
                #2;
                if (ld_stall) begin
                    seen = 1;
                    chk("starve full cycles", 32'(full_cyc), 32'd8);
                    chk("starve write", 32'(MemWrite), 32'd1);
                end else if (!st_ready) begin
                    full_cyc++;
                end
                sb_step("starve");
            end
            chk("starve seen", 32'(seen), 32'd1);
            @(negedge clk);
            st_valid = 1'b0; #2;
            chk("post-force ld_stall", 32'(ld_stall), 32'd0);
            chk("post-force st_ready", 32'(st_ready), 32'd1);
            chk("post-force ld_data", 32'(ld_data), 32'(model_load(ld_adr)));
            sb_step("postforce");
        end

        // Random mix against the scoreboard and memory model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            st_valid = ($urandom_range(0, 2) != 0);
            st_adr   = 10'h040 + 10'($urandom_range(0, 5));
            st_data  = 16'($urandom);
            ld_req   = ($urandom_range(0, 3) != 0);
            ld_adr   = 10'h040 + 10'($urandom_range(0, 7));
            #2;
            chk("rand st_ready", 32'(st_ready), 32'(sb.size() != 4));
            chk("rand empty", 32'(empty), 32'(sb.size() == 0));
            if (ld_req && !ld_stall)
                chk("rand ld_data", 32'(ld_data), 32'(model_load(ld_adr)));
            sb_step("rand");
        end

        // Drain everything that is left
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            st_valid = 1'b0; ld_req = 1'b0; #2;
            sb_step("flush");
        end
        chk("final empty", 32'(empty), 32'd1);
        chk("final sb size", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
